// File: rtl/adc_scan_sequencer_pkg.sv
// Shared types and helpers for the ADC scan sequencer.
// The state enum and the timer width are used by the top and the bench.
package adc_seq_pkg;

  localparam int SAR_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    CONVERT,
    WAIT_EOC,
    RESULT
  } state_t;

  // One timer serves both the settle count and the eoc timeout.
  function automatic int tmr_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Result port of the scan sequencer: {channel, code} with valid/ready.
// The sequencer is the master side; the consumer or FIFO is the slave.
interface adc_scan_sequencer_if #(
  parameter int CW = 2,
  parameter int DW = 8
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [CW-1:0] ch;

  modport master (output valid, data, ch, input ready);
  modport slave  (input valid, data, ch, output ready);
endinterface

// File: rtl/adc_scan_sequencer_ch_picker.sv
// Priority encoder: lowest enabled channel at or above idx.
// idx == NCH yields found = 0, so the caller sees the end of the scan.
module adc_ch_picker #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH),
  localparam int IW  = CW + 1
) (
  input  logic [NCH-1:0] mask,
  input  logic [IW-1:0]  idx,
  output logic [CW-1:0]  ch,
  output logic           found
);

  always_comb begin
    ch    = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (IW'(i) >= idx)) begin
        ch    = CW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Multi-channel scan controller for the SAR ADC.
// Define ADC_AVG_EN to average 2**AVG_LOG2 conversions per channel.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DW          = SAR_DW,
  parameter int SETTLE_CYC  = 4,
  parameter int EOC_TIMEOUT = 16,
  parameter int AVG_LOG2    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_start,
  input  logic                    scan_abort,
  input  logic                    cont_mode,
  input  logic [NCH-1:0]          ch_mask,
  output logic [$clog2(NCH)-1:0]  mux_sel,
  output logic                    sar_start,
  input  logic                    sar_eoc,
  input  logic [DW-1:0]           sar_data,
  adc_scan_sequencer_if.master    res,
  output logic                    busy,
  output logic                    scan_done,
  output logic                    timeout_err
);

  localparam int CW = $clog2(NCH);
  localparam int IW = CW + 1;
  localparam int TW = tmr_w(SETTLE_CYC, EOC_TIMEOUT);

  state_t         state, state_n;
  logic [NCH-1:0] mask, mask_n;
  logic           cont, cont_n;
  logic [IW-1:0]  idx, idx_n, nxt_idx;
  logic [CW-1:0]  mux_n, pick_ch;
  logic           pick_ok;
  logic [TW-1:0]  tmr, tmr_n;
  logic [DW-1:0]  data, data_n;
  logic           err, err_n;

`ifdef ADC_AVG_EN
  localparam int AW = DW + AVG_LOG2;
  localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  logic [AW-1:0] acc, acc_n, sum;
  logic [SW-1:0] sc, sc_n;
`endif

  adc_ch_picker #(.NCH(NCH)) u_pick (
    .mask  (mask),
    .idx   (idx),
    .ch    (pick_ch),
    .found (pick_ok)
  );

  assign nxt_idx     = {1'b0, mux_sel} + IW'(1);
  assign sar_start   = (state == CONVERT);
  assign busy        = (state != IDLE);
  assign timeout_err = err;
  assign res.valid   = (state == RESULT);
  assign res.data    = data;
  assign res.ch      = mux_sel;

  always_comb begin
    state_n   = state;
    mask_n    = mask;
    cont_n    = cont;
    idx_n     = idx;
    mux_n     = mux_sel;
    tmr_n     = tmr;
    data_n    = data;
    err_n     = err;
    scan_done = 1'b0;
`ifdef ADC_AVG_EN
    acc_n = acc;
    sc_n  = sc;
    sum   = acc + AW'(sar_data);
`endif
    if (scan_abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (scan_start) begin
            err_n = 1'b0;
            if (|ch_mask) begin
              mask_n  = ch_mask;
              cont_n  = cont_mode;
              idx_n   = '0;
              state_n = SELECT;
            end
          end
        end
        SELECT: begin
          if (pick_ok) begin
            mux_n   = pick_ch;
            tmr_n   = '0;
            state_n = (SETTLE_CYC == 0) ? CONVERT : SETTLE;
`ifdef ADC_AVG_EN
            acc_n = '0;
            sc_n  = '0;
`endif
          end else begin
            scan_done = 1'b1;
            idx_n     = '0;
            state_n   = cont ? SELECT : IDLE;
          end
        end
        SETTLE: begin
          if (tmr == TW'(SETTLE_CYC - 1)) state_n = CONVERT;
          else tmr_n = tmr + TW'(1);
        end
        CONVERT: begin
          tmr_n   = '0;
          state_n = WAIT_EOC;
        end
        WAIT_EOC: begin
          if (sar_eoc) begin
`ifdef ADC_AVG_EN
            // Back-to-back samples reuse the settled mux; no re-settle.
            if (sc == SW'((1 << AVG_LOG2) - 1)) begin
              data_n  = DW'(sum >> AVG_LOG2);
              state_n = RESULT;
            end else begin
              acc_n   = sum;
              sc_n    = sc + SW'(1);
              state_n = CONVERT;
            end
`else
            data_n  = sar_data;
            state_n = RESULT;
`endif
          end else if (tmr == TW'(EOC_TIMEOUT - 1)) begin
            err_n   = 1'b1;
            idx_n   = nxt_idx;
            state_n = SELECT;
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
        RESULT: begin
          if (res.ready) begin
            idx_n   = nxt_idx;
            state_n = SELECT;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mask    <= '0;
      cont    <= 1'b0;
      idx     <= '0;
      mux_sel <= '0;
      tmr     <= '0;
      data    <= '0;
      err     <= 1'b0;
`ifdef ADC_AVG_EN
      acc <= '0;
      sc  <= '0;
`endif
    end else begin
      state   <= state_n;
      mask    <= mask_n;
      cont    <= cont_n;
      idx     <= idx_n;
      mux_sel <= mux_n;
      tmr     <= tmr_n;
      data    <= data_n;
      err     <= err_n;
`ifdef ADC_AVG_EN
      acc <= acc_n;
      sc  <= sc_n;
`endif
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer with a behavioural SAR model.
// Build with ADC_AVG_EN defined to exercise the averaging scenario too.
module tb_adc_scan_sequencer;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           scan_start = 1'b0;
  logic           scan_abort = 1'b0;
  logic           cont_mode = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic [CW-1:0]  mux_sel;
  logic           sar_start;
  logic           sar_eoc = 1'b0;
  logic [DW-1:0]  sar_data = '0;
  logic           busy, scan_done, timeout_err;

  logic [NCH-1:0] dead = '0;
  logic           use_tbl = 1'b0;
  logic [DW-1:0]  codes [4];
  logic [CW-1:0]  conv_ch = '0;
  int             cnt = 0;
  int             conv_n = 0;

  int n_run = 0, n_fail = 0;
  int starts = 0, dones = 0, n_extra = 0;
  int s0, d0;
  logic [CW+DW-1:0] exp_q [$];
  logic [CW+DW-1:0] e;

  adc_scan_sequencer_if #(.CW(CW), .DW(DW)) res ();

  adc_scan_sequencer #(
    .NCH(NCH), .DW(DW), .SETTLE_CYC(4), .EOC_TIMEOUT(16), .AVG_LOG2(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_start  (scan_start),
    .scan_abort  (scan_abort),
    .cont_mode   (cont_mode),
    .ch_mask     (ch_mask),
    .mux_sel     (mux_sel),
    .sar_start   (sar_start),
    .sar_eoc     (sar_eoc),
    .sar_data    (sar_data),
    .res         (res),
    .busy        (busy),
    .scan_done   (scan_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SAR model: eoc 10 cycles after sar_start; dead channels never answer.
  always @(negedge clk) begin
    sar_eoc = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        sar_eoc  = 1'b1;
        sar_data = use_tbl ? codes[conv_n % 4] : 8'h10 + {6'b0, conv_ch};
        conv_n++;
      end
    end
    if (sar_start && !dead[mux_sel]) begin
      cnt     = 10;
      conv_ch = mux_sel;
    end
  end

  always @(negedge clk) begin
    if (sar_start) starts++;
    if (scan_done) dones++;
    if (res.valid && res.ready) begin
      if (exp_q.size() == 0) begin
        n_extra++;
      end else begin
        e = exp_q.pop_front();
        chk("res_ch", {30'b0, res.ch}, {30'b0, e[CW+DW-1:DW]});
        chk("res_data", {24'b0, res.data}, {24'b0, e[DW-1:0]});
      end
    end
  end

  task automatic start_scan();
    @(posedge clk); #1 scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int k = 0;
    while (dones < target && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk("scan_done_cnt", dones, target);
  endtask

  initial begin
    codes[0] = 8'd100; codes[1] = 8'd101;
    codes[2] = 8'd102; codes[3] = 8'd104;
    res.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", res.valid, 0);
    chk("rst_mux", mux_sel, 0);
    chk("rst_start", sar_start, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_done", scan_done, 0);
    rst = 1'b0;

    // single scan over channels 0,1,3
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd3, 8'h13});
    ch_mask = 4'b1011;
    d0 = dones;
    @(posedge clk); #1 scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("lat_pre", sar_start, 0);
    @(posedge clk);
    #1 chk("lat_start", sar_start, 1);
    wait_dones(d0 + 1, 400);
    @(posedge clk); #1;
    chk("t1_idle", busy, 0);
    chk("t1_q", exp_q.size(), 0);
    chk("t1_one_done", dones, d0 + 1);
    chk("t1_err", timeout_err, 0);

    // backpressure: result held while ready is low
    exp_q.push_back({2'd0, 8'h10});
    ch_mask = 4'b0001;
    res.ready = 1'b0;
    d0 = dones;
    start_scan();
    for (int k = 0; k < 200 && !res.valid; k++) @(posedge clk);
    #1 chk("t2_valid", res.valid, 1);
    s0 = starts;
    repeat (20) @(posedge clk);
    #1;
    chk("t2_hold_valid", res.valid, 1);
    chk("t2_hold_data", res.data, 8'h10);
    chk("t2_hold_ch", res.ch, 0);
    chk("t2_hold_mux", mux_sel, 0);
    chk("t2_no_start", starts, s0);
    res.ready = 1'b1;
    wait_dones(d0 + 1, 100);
    chk("t2_q", exp_q.size(), 0);

    // channel 1 never answers
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd3, 8'h13});
    dead = 4'b0010;
    ch_mask = 4'b1011;
    d0 = dones;
    start_scan();
    wait_dones(d0 + 1, 400);
    chk("t3_err", timeout_err, 1);
    chk("t3_q", exp_q.size(), 0);
    dead = '0;
    repeat (3) @(posedge clk);

    // continuous mode, then abort during settle
    repeat (3) exp_q.push_back({2'd0, 8'h10});
    cont_mode = 1'b1;
    ch_mask = 4'b0001;
    d0 = dones;
    start_scan();
    #1 chk("t4_err_clr", timeout_err, 0);
    cont_mode = 1'b0;
    wait_dones(d0 + 3, 600);
    @(posedge clk);
    @(posedge clk);
    #1 s0 = starts;
    scan_abort = 1'b1;
    @(posedge clk); #1 scan_abort = 1'b0;
    chk("t4_abort_idle", busy, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("t4_no_start", starts, s0);
    chk("t4_q", exp_q.size(), 0);
    chk("t4_dones", dones, d0 + 3);

    // zero mask, abort racing start, reset mid-conversion
    ch_mask = '0;
    d0 = dones;
    start_scan();
    #1 chk("t5_zero_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 chk("t5_zero_done", dones, d0);
    ch_mask = 4'b0001;
    @(posedge clk); #1 scan_start = 1'b1; scan_abort = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0; scan_abort = 1'b0;
    chk("t5_abort_wins", busy, 0);
    ch_mask = 4'b0100;
    start_scan();
    for (int k = 0; k < 50 && !sar_start; k++) begin
      @(negedge clk); #1;
    end
    chk("t5_converting", sar_start, 1);
    @(posedge clk); #1;
    chk("t5_wait_mux", mux_sel, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_mux", mux_sel, 0);
    chk("t5_rst_valid", res.valid, 0);
    chk("t5_rst_data", res.data, 0);
    chk("t5_rst_ch", res.ch, 0);
    chk("t5_rst_start", sar_start, 0);
    chk("t5_rst_done", scan_done, 0);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    chk("t5_idle", busy, 0);

`ifdef ADC_AVG_EN
    // four samples 100,101,102,104 average to 101
    conv_n = 0;
    use_tbl = 1'b1;
    exp_q.push_back({2'd0, 8'd101});
    ch_mask = 4'b0001;
    d0 = dones;
    s0 = starts;
    start_scan();
    wait_dones(d0 + 1, 400);
    chk("t6_starts", starts - s0, 4);
    chk("t6_q", exp_q.size(), 0);
    use_tbl = 1'b0;
`endif

    chk("no_extra", n_extra, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
